stdrain: RTL and testbench

- Read-side companion to the hold-latch cells in the TOM register path.
- A producer strobes words in with a single-cycle enable.
- stdrain buffers those words and presents them one at a time to a consumer, holding each word stable until the consumer acknowledges it.
- Sits between a latched register source (blitter/GPU status capture) and a slower readout port.

---
 rtl/stdrain_pkg.sv | 18 +
 rtl/stdrain_ram.sv | 28 ++
 rtl/stdrain.sv | 118 +++++++++++
 tb/tb_stdrain.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/stdrain_pkg.sv
// Shared constants and helpers for the stdrain read-side drain buffer.
package stdrain_pkg;

    localparam int DEFAULT_WIDTH = 16;
    localparam int DEFAULT_DEPTH = 4;
    localparam int OVF_CNT_W     = 8;

    // Smallest w with 2**w >= depth; depth is a power of two >= 2.
    function automatic int ptr_width(input int depth);
        int w;
        w = 0;
        while ((1 << w) < depth) begin
            w = w + 1;
        end
        return w;
    endfunction

endpackage

// File: rtl/stdrain_ram.sv
// DEPTH x WIDTH register file: one synchronous write port, one asynchronous read port.
module stdrain_ram
    import stdrain_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int DEPTH = DEFAULT_DEPTH,
    localparam int AW = ptr_width(DEPTH)
) (
    input  logic             sys_clk,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    // Contents are never reset; the pointer and count logic decides what is valid.
    always_ff @(posedge sys_clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/stdrain.sv
// stdrain: buffers strobed producer words and presents them one at a time, held until acknowledged.
// Build option STDRAIN_OVF_EN adds a sticky ovf flag and a saturating ovf_cnt of dropped words.
module stdrain
    import stdrain_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int DEPTH = DEFAULT_DEPTH,
    localparam int AW = ptr_width(DEPTH)
) (
    input  logic                 sys_clk,
    input  logic                 resetl,
    input  logic                 wr_en,
    input  logic [WIDTH-1:0]     wr_d,
    output logic                 full,
    output logic [WIDTH-1:0]     dout,
    output logic                 dout_vld,
    input  logic                 rd_ack,
    output logic [AW+1:0]        level
`ifdef STDRAIN_OVF_EN
    ,
    output logic                 ovf,
    output logic [OVF_CNT_W-1:0] ovf_cnt
`endif
);

    localparam logic [AW:0] CNT_MAX = (AW+1)'(DEPTH);

    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      cnt;
    logic [WIDTH-1:0] ram_rdata;

    logic             free;
    logic             pop;
    logic             bypass;
    logic             push;
    logic [AW:0]      cnt_next;
    logic             vld_next;
    logic [WIDTH-1:0] dout_next;
    logic [AW+1:0]    level_next;
`ifdef STDRAIN_OVF_EN
    logic             drop;
`endif

    stdrain_ram #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_ram (
        .sys_clk (sys_clk),
        .we      (push),
        .waddr   (wr_ptr),
        .wdata   (wr_d),
        .raddr   (rd_ptr),
        .rdata   (ram_rdata)
    );

    // The output register is refilled when it is empty or being acknowledged; storage
    // has priority over the bypass so ordering stays strictly first-in first-out.
    always_comb begin
        free       = !dout_vld || rd_ack;
        pop        = free && (cnt != '0);
        bypass     = free && (cnt == '0) && wr_en;
        push       = wr_en && !bypass && ((cnt != CNT_MAX) || pop);
        cnt_next   = cnt + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
        vld_next   = pop || bypass || !free;
        dout_next  = dout;
        if (pop) begin
            dout_next = ram_rdata;
        end else if (bypass) begin
            dout_next = wr_d;
        end
        level_next = {1'b0, cnt_next} + {{(AW+1){1'b0}}, vld_next};
`ifdef STDRAIN_OVF_EN
        drop       = wr_en && !bypass && !push;
`endif
    end

    // Pointers, occupancy and the held output word; full and level are registered views.
    always_ff @(posedge sys_clk or negedge resetl) begin
        if (!resetl) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            cnt      <= '0;
            dout     <= '0;
            dout_vld <= 1'b0;
            full     <= 1'b0;
            level    <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            cnt      <= cnt_next;
            dout     <= dout_next;
            dout_vld <= vld_next;
            full     <= (cnt_next == CNT_MAX);
            level    <= level_next;
        end
    end

`ifdef STDRAIN_OVF_EN
    // Overflow history survives until reset; the drop counter stops at all-ones.
    always_ff @(posedge sys_clk or negedge resetl) begin
        if (!resetl) begin
            ovf     <= 1'b0;
            ovf_cnt <= '0;
        end else if (drop) begin
            ovf <= 1'b1;
            if (ovf_cnt != '1) begin
                ovf_cnt <= ovf_cnt + OVF_CNT_W'(1);
            end
        end
    end
`endif

endmodule

// File: tb/tb_stdrain.sv
// Directed scoreboard bench for stdrain: a word queue models what the consumer should see.
module tb_stdrain;
    import stdrain_pkg::*;

    localparam int W  = DEFAULT_WIDTH;
    localparam int D  = DEFAULT_DEPTH;
    localparam int LW = ptr_width(D) + 2;

    logic          sys_clk = 1'b0;
    logic          resetl;
    logic          wr_en;
    logic [W-1:0]  wr_d;
    logic          full;
    logic [W-1:0]  dout;
    logic          dout_vld;
    logic          rd_ack;
    logic [LW-1:0] level;
`ifdef STDRAIN_OVF_EN
    logic          ovf;
    logic [7:0]    ovf_cnt;
`endif

    int           compared   = 0;
    int           mismatched = 0;
    logic [W-1:0] exp_q[$];
    logic [W-1:0] exp_hold;
    int           exp_drops;

    stdrain dut (
        .sys_clk  (sys_clk),
        .resetl   (resetl),
        .wr_en    (wr_en),
        .wr_d     (wr_d),
        .full     (full),
        .dout     (dout),
        .dout_vld (dout_vld),
        .rd_ack   (rd_ack),
        .level    (level)
`ifdef STDRAIN_OVF_EN
        ,
        .ovf      (ovf),
        .ovf_cnt  (ovf_cnt)
`endif
    );

    always #5 sys_clk = ~sys_clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Compares every DUT output with what the queue model says is held right now.
    task automatic checkOutput(input string where);
        logic [W-1:0] exp_dout;
        int           n;
        n        = exp_q.size();
        exp_dout = (n > 0) ? exp_q[0] : exp_hold;
        check({where, ":dout_vld"}, 32'(dout_vld), 32'(n > 0));
        check({where, ":dout"},     32'(dout),     32'(exp_dout));
        check({where, ":level"},    32'(level),    32'(n));
        check({where, ":full"},     32'(full),     32'(n == D + 1));
`ifdef STDRAIN_OVF_EN
        check({where, ":ovf"},      32'(ovf),      32'(exp_drops > 0));
        check({where, ":ovf_cnt"},  32'(ovf_cnt),  32'((exp_drops > 255) ? 255 : exp_drops));
`endif
    endtask

    // Drives one cycle of stimulus from a falling edge and updates the model queue.
    task automatic applyStimulus(input logic we, input logic [W-1:0] d, input logic ack);
        wr_en  = we;
        wr_d   = d;
        rd_ack = ack;
        if (ack && exp_q.size() > 0) begin
            exp_hold = exp_q.pop_front();
        end
        if (we) begin
            if (exp_q.size() < D + 1) begin
                exp_q.push_back(d);
            end else begin
                exp_drops++;
            end
        end
        @(posedge sys_clk);
        @(negedge sys_clk);
        wr_en  = 1'b0;
        rd_ack = 1'b0;
    endtask

    task automatic modelReset();
        exp_q.delete();
        exp_hold  = '0;
        exp_drops = 0;
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        resetl = 1'b0;
        wr_en  = 1'b0;
        wr_d   = '0;
        rd_ack = 1'b0;
        modelReset();
        repeat (3) @(negedge sys_clk);
        checkOutput("reset");
        resetl = 1'b1;

        $display("[TB] single write");
        applyStimulus(1'b0, '0, 1'b0);
        applyStimulus(1'b1, 16'h1234, 1'b0);
        checkOutput("single_write");
        applyStimulus(1'b0, '0, 1'b1);
        checkOutput("single_ack");

        $display("[TB] fill and drain");
        for (int i = 1; i <= 6; i++) begin
            applyStimulus(1'b1, W'(i), 1'b0);
            checkOutput($sformatf("fill_%0d", i));
        end
        for (int i = 0; i < 6; i++) begin
            applyStimulus(1'b0, '0, 1'b1);
            checkOutput($sformatf("drain_%0d", i));
        end

        $display("[TB] simultaneous write and ack at full");
        for (int i = 0; i < 5; i++) begin
            applyStimulus(1'b1, 16'h0100 + W'(i), 1'b0);
        end
        checkOutput("refill");
        applyStimulus(1'b1, 16'hAAAA, 1'b1);
        checkOutput("simul_full");
        for (int i = 0; i < 6; i++) begin
            applyStimulus(1'b0, '0, 1'b1);
            checkOutput($sformatf("simul_drain_%0d", i));
        end

        $display("[TB] streaming with wrap");
        for (int i = 0; i < 20; i++) begin
            applyStimulus(1'b1, 16'h5000 + W'(i), 1'b1);
            checkOutput($sformatf("stream_%0d", i));
        end
        applyStimulus(1'b0, '0, 1'b1);
        checkOutput("stream_end");

        $display("[TB] reset mid-operation");
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b1, 16'h7700 + W'(i), 1'b0);
        end
        checkOutput("pre_reset");
        #2;
        resetl = 1'b0;
        #1;
        modelReset();
        checkOutput("async_reset");
        @(negedge sys_clk);
        resetl = 1'b1;
        checkOutput("reset_release");
        applyStimulus(1'b1, 16'h1234, 1'b0);
        checkOutput("post_reset_write");
        applyStimulus(1'b0, '0, 1'b1);
        checkOutput("post_reset_ack");

        $display("[TB] spurious ack");
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b0, '0, 1'b1);
            checkOutput($sformatf("spurious_%0d", i));
        end
        applyStimulus(1'b1, 16'h0F0F, 1'b0);
        checkOutput("spurious_write");
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b0, '0, 1'b0);
            checkOutput($sformatf("hold_%0d", i));
        end
        applyStimulus(1'b0, '0, 1'b1);
        checkOutput("final_ack");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
